// File: rtl/read_dec.sv
// read_dec: read-side pointer and empty-flag controller for a dual-clock FIFO.
// Everything here runs in the rclk domain. The write-domain Gray pointer is
// brought in through a two-flop synchronizer. The binary/Gray read pointer
// advances on accepted reads. Empty, almost-empty and the read-side occupancy
// are registered.
//
// Ports:
//   rclk          read clock, rising edge
//   rst           synchronous active-high reset
//   signal_read   read request
//   graycode_wptr write-domain Gray pointer (asynchronous to rclk)
//   read_address  memory read address (low bits of the binary read counter)
//   rd_en         memory read strobe: signal_read & ~empty & ~rst
//   graycode_rptr registered read Gray pointer, sent to the write domain
//   empty         registered, no readable entries
//   almost_empty  registered, occupancy <= AE_THRESH
//   rd_count      registered occupancy as seen by the read side
module read_dec #(
  parameter int          ADDRSIZE  = 4,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rst,
  input  logic                signal_read,
  input  logic [ADDRSIZE:0]   graycode_wptr,
  output logic [ADDRSIZE-1:0] read_address,
  output logic                rd_en,
  output logic [ADDRSIZE:0]   graycode_rptr,
  output logic                empty,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   rd_count
);

  // XOR prefix from the MSB down turns a Gray code back into binary.
  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDRSIZE:0] wq1;
  logic [ADDRSIZE:0] wq2;
  logic [ADDRSIZE:0] read_counter;

  logic              rd_inc;
  logic [ADDRSIZE:0] next_read;
  logic [ADDRSIZE:0] next_gray;
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] next_count;
  logic              next_empty;
  logic              next_ae;

  // Next-state logic: the read accepted this cycle is folded into the flags
  // computed for the same edge, so empty never lags a read by a cycle.
  always_comb begin
    rd_inc     = signal_read & ~empty;
    next_read  = read_counter + {{ADDRSIZE{1'b0}}, rd_inc};
    next_gray  = next_read ^ (next_read >> 1);
    // Full-width compare: the MSB distinguishes empty from a full wrap.
    next_empty = (next_gray == wq2);
    wbin       = gray2bin(wq2);
    // Modular subtraction keeps the occupancy correct across pointer wrap.
    next_count = wbin - next_read;
    next_ae    = (32'(next_count) <= AE_THRESH);
  end

  assign rd_en        = rd_inc & ~rst;
  assign read_address = read_counter[ADDRSIZE-1:0];

  // Registered stage: synchronizer, read pointer and flags share one edge.
  always_ff @(posedge rclk) begin
    if (rst) begin
      wq1           <= '0;
      wq2           <= '0;
      read_counter  <= '0;
      graycode_rptr <= '0;
      empty         <= 1'b1;
      almost_empty  <= 1'b1;
      rd_count      <= '0;
    end else begin
      wq1           <= graycode_wptr;
      wq2           <= wq1;
      read_counter  <= next_read;
      graycode_rptr <= next_gray;
      empty         <= next_empty;
      almost_empty  <= next_ae;
      rd_count      <= next_count;
    end
  end

endmodule

// File: tb/tb_read_dec.sv
// Bench for read_dec (ADDRSIZE=4, AE_THRESH=2). A behavioural model tracks the
// write pointer as seen through two synchronizer stages and the read pointer
// as plain integers; occupancy is their modular difference and the flags are
// derived from it. A compare process checks every output on each falling edge,
// and a directed sequence pins the model with hand-computed literals before a
// randomized phase.
module tb_read_dec;
  localparam int AW = 4;

  logic          rclk = 1'b0;
  logic          rst;
  logic          signal_read;
  logic [AW:0]   graycode_wptr;
  logic [AW-1:0] read_address;
  logic          rd_en;
  logic [AW:0]   graycode_rptr;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   rd_count;

  read_dec #(.ADDRSIZE(AW), .AE_THRESH(2)) dut (
    .rclk         (rclk),
    .rst          (rst),
    .signal_read  (signal_read),
    .graycode_wptr(graycode_wptr),
    .read_address (read_address),
    .rd_en        (rd_en),
    .graycode_rptr(graycode_rptr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int g2b(input logic [AW:0] g);
    int b = 0;
    for (int i = AW; i >= 0; i--) begin
      b = b * 2 + ((b % 2) ^ int'(g[i]));
    end
    return b;
  endfunction

  function automatic logic [AW:0] b2g(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  // Behavioural model: integers only, updated at each rising edge.
  int m_w1, m_w2;   // write pointer (binary) after one and two sync stages
  int m_rptr;       // binary read pointer, modulo 32
  int m_cnt;        // occupancy seen by the read side

  always @(posedge rclk) begin
    if (rst) begin
      m_w1 = 0; m_w2 = 0; m_rptr = 0; m_cnt = 0;
    end else begin
      if (signal_read && m_cnt != 0) m_rptr = (m_rptr + 1) % 32;
      m_cnt = (m_w2 - m_rptr + 32) % 32;
      m_w2  = m_w1;
      m_w1  = g2b(graycode_wptr);
    end
  end

  always @(negedge rclk) begin
    if (chk_en) begin
      chk("addr",  32'(read_address),  32'(m_rptr % 16));
      chk("rptr",  32'(graycode_rptr), 32'(b2g(m_rptr)));
      chk("count", 32'(rd_count),      32'(m_cnt));
      chk("empty", 32'(empty),         32'(m_cnt == 0));
      chk("ae",    32'(almost_empty),  32'(m_cnt <= 2));
      chk("rd_en", 32'(rd_en),         32'(signal_read && !rst && m_cnt != 0));
    end
  end

  task automatic tick;
    @(posedge rclk);
    #2;
  endtask

  int wb;
  bit found;

  initial begin
    // Reset with a read request and a nonzero write pointer pending.
    rst = 1'b1; signal_read = 1'b1; graycode_wptr = 5'b00011;
    tick; chk_en = 1'b1; tick;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_count", 32'(rd_count), 0);
    chk("rst_rptr", 32'(graycode_rptr), 0);
    chk("rst_addr", 32'(read_address), 0);
    chk("rst_rd_en", 32'(rd_en), 0);

    // Read while empty: pointer must not move.
    rst = 1'b0; signal_read = 1'b1; graycode_wptr = '0;
    repeat (5) begin
      tick;
      chk("re_addr", 32'(read_address), 0);
      chk("re_rd_en", 32'(rd_en), 0);
    end

    // Single entry: visible two edges after the capturing edge.
    signal_read = 1'b0; graycode_wptr = 5'b00001;
    tick; tick;
    chk("se_empty_n1", 32'(empty), 1);
    tick;
    chk("se_empty_n2", 32'(empty), 0);
    chk("se_count_n2", 32'(rd_count), 1);
    signal_read = 1'b1; #1;
    chk("se_rd_en", 32'(rd_en), 1);
    tick; signal_read = 1'b0;
    chk("se_addr", 32'(read_address), 1);
    chk("se_rptr", 32'(graycode_rptr), 5'b00001);
    chk("se_empty", 32'(empty), 1);
    chk("se_count", 32'(rd_count), 0);

    // Wrap: 16 entries read back to back.
    rst = 1'b1; graycode_wptr = '0; tick; rst = 1'b0;
    graycode_wptr = 5'b11000;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick;
      if (rd_count == 5'd16) found = 1'b1;
    end
    chk("wr_full_seen", 32'(found), 1);
    signal_read = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick;
      chk("wr_addr", 32'(read_address), 32'((i + 1) % 16));
    end
    signal_read = 1'b0;
    chk("wr_rptr", 32'(graycode_rptr), 5'b11000);
    chk("wr_empty", 32'(empty), 1);
    chk("wr_count", 32'(rd_count), 0);
    graycode_wptr = 5'b11001;
    tick; tick;
    chk("wr_empty_n1", 32'(empty), 1);
    tick;
    chk("wr_empty_n2", 32'(empty), 0);

    // almost_empty threshold and simultaneous read/write accounting.
    rst = 1'b1; graycode_wptr = '0; tick; rst = 1'b0;
    graycode_wptr = 5'b00110;
    tick; tick; tick;
    chk("ae_count4", 32'(rd_count), 4);
    chk("ae_off", 32'(almost_empty), 0);
    signal_read = 1'b1; tick; tick; signal_read = 1'b0;
    chk("ae_count2", 32'(rd_count), 2);
    chk("ae_on", 32'(almost_empty), 1);
    graycode_wptr = 5'b00111;
    tick;
    chk("sim_hold", 32'(rd_count), 2);
    tick; signal_read = 1'b1; tick; signal_read = 1'b0;
    chk("sim_count", 32'(rd_count), 2);
    chk("sim_addr", 32'(read_address), 3);
    chk("sim_ae", 32'(almost_empty), 1);

    // Reset in the middle of continuous reads.
    rst = 1'b1; graycode_wptr = '0; tick; rst = 1'b0;
    graycode_wptr = 5'b00111;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick;
      if (rd_count == 5'd5) found = 1'b1;
    end
    chk("mr_count5_seen", 32'(found), 1);
    signal_read = 1'b1; tick;
    chk("mr_count4", 32'(rd_count), 4);
    rst = 1'b1; #1;
    chk("mr_rd_en", 32'(rd_en), 0);
    tick;
    chk("mr_empty", 32'(empty), 1);
    chk("mr_ae", 32'(almost_empty), 1);
    chk("mr_count", 32'(rd_count), 0);
    chk("mr_rptr", 32'(graycode_rptr), 0);
    chk("mr_addr", 32'(read_address), 0);
    rst = 1'b0; signal_read = 1'b0;
    tick; tick;
    chk("mr_empty_n1", 32'(empty), 1);
    tick;
    chk("mr_empty_n2", 32'(empty), 0);
    chk("mr_count_n2", 32'(rd_count), 5);

    // Randomized phase: legal write-pointer advances, random reads and resets.
    rst = 1'b1; signal_read = 1'b0; graycode_wptr = '0; tick; rst = 1'b0;
    wb = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; wb = 0;
      end else begin
        rst = 1'b0;
        if ($urandom_range(0, 1) == 1 && ((wb - m_rptr + 32) % 32) < 16)
          wb = (wb + 1) % 32;
      end
      graycode_wptr = b2g(wb);
      signal_read = ($urandom_range(0, 2) != 0);
      tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end
endmodule
